// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor. Operands are split into STAGES carry-linked chunks.
// One chunk is added per register stage, with valid/ready handshakes on both ends.
module pipelined_addsub #(
    parameter int WIDTH  = 30,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH + STAGES - 1) / STAGES;
    localparam int LW = WIDTH - (STAGES - 1) * CW;
    localparam logic [WIDTH:0] CHUNK_MASK = {(WIDTH + 1){1'b1}} >> (WIDTH + 1 - CW);
    localparam logic [WIDTH:0] LAST_MASK  = {(WIDTH + 1){1'b1}} >> (WIDTH + 1 - LW);

    if (STAGES < 1 || LW < 1) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH=%0d cannot be split into STAGES=%0d chunks", WIDTH, STAGES);
    end

    // Adds chunk idx of x and y plus ci; returns {carry_out, res with that chunk filled in}.
    function automatic logic [WIDTH:0] add_chunk(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] res,
                                                 input logic             ci,
                                                 input int               idx);
        logic [WIDTH:0] m;
        logic [WIDTH:0] t;
        m = (idx == STAGES - 1) ? LAST_MASK : CHUNK_MASK;
        t = (({1'b0, x} >> (idx * CW)) & m) + (({1'b0, y} >> (idx * CW)) & m)
            + {{WIDTH{1'b0}}, ci};
        add_chunk = {|(t & ~m), res | WIDTH'((t & m) << (idx * CW))};
    endfunction

    logic [WIDTH-1:0]  opa_r     [STAGES];
    logic [WIDTH-1:0]  opb_r     [STAGES];
    logic [WIDTH-1:0]  res_r     [STAGES];
    logic              amsb_r    [STAGES];
    logic              bmsb_r    [STAGES];
    logic [STAGES-1:0] cy_r;
    logic [STAGES-1:0] v_r;
    logic              ovf_r;

    logic [WIDTH-1:0]  b_eff_s;
    logic [WIDTH-1:0]  src_a_s   [STAGES];
    logic [WIDTH-1:0]  src_b_s   [STAGES];
    logic [WIDTH-1:0]  src_res_s [STAGES];
    logic              src_amsb_s[STAGES];
    logic              src_bmsb_s[STAGES];
    logic [STAGES-1:0] src_cy_s;
    logic [STAGES-1:0] src_v_s;
    logic [WIDTH-1:0]  nxt_res_s [STAGES];
    logic [STAGES-1:0] nxt_cy_s;
    logic [STAGES-1:0] load_s;
    logic              ovf_nxt_s;

    // Stage sources: stage 0 takes the transformed operands, later stages take their predecessor.
    always_comb begin
        b_eff_s       = sub ? ~b : b;
        src_cy_s      = {STAGES{1'b0}};
        src_v_s       = {STAGES{1'b0}};
        src_a_s[0]    = a;
        src_b_s[0]    = b_eff_s;
        src_res_s[0]  = {WIDTH{1'b0}};
        src_amsb_s[0] = a[WIDTH-1];
        src_bmsb_s[0] = b_eff_s[WIDTH-1];
        src_cy_s[0]   = cin ^ sub;
        src_v_s[0]    = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            src_a_s[i]    = opa_r[i-1];
            src_b_s[i]    = opb_r[i-1];
            src_res_s[i]  = res_r[i-1];
            src_amsb_s[i] = amsb_r[i-1];
            src_bmsb_s[i] = bmsb_r[i-1];
            src_cy_s[i]   = cy_r[i-1];
            src_v_s[i]    = v_r[i-1];
        end
    end

    // Per-stage chunk add and the overflow flag formed at the final stage.
    always_comb begin
        nxt_cy_s = {STAGES{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            {nxt_cy_s[i], nxt_res_s[i]} = add_chunk(src_a_s[i], src_b_s[i], src_res_s[i],
                                                    src_cy_s[i], i);
        end
        ovf_nxt_s = (src_amsb_s[STAGES-1] == src_bmsb_s[STAGES-1]) &&
                    (nxt_res_s[STAGES-1][WIDTH-1] != src_amsb_s[STAGES-1]);
    end

    // A stage loads when any stage at or after it is empty, or the output is being taken.
    always_comb begin
        load_s = {STAGES{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            load_s[i] = out_ready || !(&(v_r | ({STAGES{1'b1}} >> (STAGES - i))));
        end
    end

    // Pipeline registers; a stage that does not load holds, which keeps a stalled output stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                opa_r[i]  <= {WIDTH{1'b0}};
                opb_r[i]  <= {WIDTH{1'b0}};
                res_r[i]  <= {WIDTH{1'b0}};
                amsb_r[i] <= 1'b0;
                bmsb_r[i] <= 1'b0;
            end
            cy_r  <= {STAGES{1'b0}};
            v_r   <= {STAGES{1'b0}};
            ovf_r <= 1'b0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (load_s[i]) begin
                    opa_r[i]  <= src_a_s[i];
                    opb_r[i]  <= src_b_s[i];
                    res_r[i]  <= nxt_res_s[i];
                    amsb_r[i] <= src_amsb_s[i];
                    bmsb_r[i] <= src_bmsb_s[i];
                    cy_r[i]   <= nxt_cy_s[i];
                    v_r[i]    <= src_v_s[i];
                end
            end
            if (load_s[STAGES-1]) begin
                ovf_r <= ovf_nxt_s;
            end
        end
    end

    assign in_ready  = load_s[0];
    assign out_valid = v_r[STAGES-1];
    assign sum       = res_r[STAGES-1];
    assign cout      = cy_r[STAGES-1];
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: a 30/3 instance with handshake traffic, plus 30/1 and 10/4
// instances fed in lock step, all checked against an arithmetic reference with queues.
module tb_pipelined_addsub;
    localparam int W  = 30;
    localparam int S  = 3;
    localparam int W2 = 10;
    localparam int S2 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    logic         aux_ready;
    logic         p_in_valid, p_in_ready, p_out_valid, p_cout, p_ovf;
    logic [W-1:0] p_sum;
    logic          n_in_valid, n_in_ready, n_out_valid, n_cout, n_ovf;
    logic [W2-1:0] n_a, n_b, n_sum;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf));

    pipelined_addsub #(.WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(p_out_valid), .out_ready(aux_ready),
        .sum(p_sum), .cout(p_cout), .ovf(p_ovf));

    pipelined_addsub #(.WIDTH(W2), .STAGES(S2)) u_narrow (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .a(n_a), .b(n_b),
        .cin(cin), .sub(sub), .out_valid(n_out_valid), .out_ready(aux_ready),
        .sum(n_sum), .cout(n_cout), .ovf(n_ovf));

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          t;
    } exp_t;

    exp_t q[$];
    exp_t pq[$];
    exp_t nq[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    int   delivered = 0;
    bit   accepted;
    bit   lat_chk;

    // Reference: plain integer add/subtract, unsigned for sum/cout, signed range test for ovf.
    function automatic exp_t model(input int wd, input longint ua, input longint ub,
                                   input longint ci, input longint sb, input int due);
        longint m, h, r, sa, sbv, rs;
        exp_t   e;
        m   = longint'(1) << wd;
        h   = m / 2;
        r   = (sb != 0) ? ua - ub - ci : ua + ub + ci;
        e.s = 32'(r & (m - 1));
        e.c = (sb != 0) ? (r >= 0) : (r >= m);
        sa  = (ua >= h) ? ua - m : ua;
        sbv = (ub >= h) ? ub - m : ub;
        rs  = (sb != 0) ? sa - sbv - ci : sa + sbv + ci;
        e.o = (rs < -h) || (rs > h - 1);
        e.t = due;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_beat", 64'(out_valid), 64'(1'b0));
            end else begin
                e = q.pop_front();
                check("sum", 64'(sum), 64'(e.s[W-1:0]));
                check("cout", 64'(cout), 64'(e.c));
                check("ovf", 64'(ovf), 64'(e.o));
                if (lat_chk) check("latency", 64'(step_no - e.t), 64'(S));
                delivered++;
            end
        end
        if (pq.size() > 0 && pq[0].t == step_no) begin
            e = pq.pop_front();
            check("s1_valid", 64'(p_out_valid), 64'(1'b1));
            check("s1_sum", 64'(p_sum), 64'(e.s[W-1:0]));
            check("s1_cout", 64'(p_cout), 64'(e.c));
            check("s1_ovf", 64'(p_ovf), 64'(e.o));
        end else begin
            check("s1_idle", 64'(p_out_valid), 64'(1'b0));
        end
        if (nq.size() > 0 && nq[0].t == step_no) begin
            e = nq.pop_front();
            check("n_valid", 64'(n_out_valid), 64'(1'b1));
            check("n_sum", 64'(n_sum), 64'(e.s[W2-1:0]));
            check("n_cout", 64'(n_cout), 64'(e.c));
            check("n_ovf", 64'(n_ovf), 64'(e.o));
        end else begin
            check("n_idle", 64'(n_out_valid), 64'(1'b0));
        end
        accepted = in_valid && in_ready;
        if (accepted) q.push_back(model(W, longint'(a), longint'(b), longint'(cin), longint'(sub), step_no));
        if (p_in_valid) begin
            check("s1_in_ready", 64'(p_in_ready), 64'(1'b1));
            pq.push_back(model(W, longint'(a), longint'(b), longint'(cin), longint'(sub), step_no + 1));
        end
        if (n_in_valid) begin
            check("n_in_ready", 64'(n_in_ready), 64'(1'b1));
            nq.push_back(model(W2, longint'(n_a), longint'(n_b), longint'(cin), longint'(sub), step_no + S2));
        end
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c, input logic s);
        in_valid = 1'b1; a = av; b = bv; cin = c; sub = s;
        accepted = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (accepted) break;
        end
        check("accept_timeout", 64'(accepted), 64'(1'b1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; p_in_valid = 1'b0; n_in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 100 && (q.size() + pq.size() + nq.size()) > 0; k++) step();
        check("drain_empty", 64'(q.size() + pq.size() + nq.size()), 64'(0));
    endtask

    task automatic fill3();
        int cnt;
        cnt = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 20 && cnt < 3; k++) begin
            in_valid = 1'b1; a = W'($urandom()); b = W'($urandom());
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            step();
            if (accepted) cnt++;
        end
        check("fill_count", 64'(cnt), 64'(3));
    endtask

    initial begin
        longint av, bv;
        int     d0, cnt;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1; aux_ready = 1'b1; p_in_valid = 1'b0; n_in_valid = 1'b0;
        n_a = '0; n_b = '0; lat_chk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(1'b0));
        check("rst_ovf", 64'(ovf), 64'(1'b0));
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1'b1));

        send(30'd3, 30'd6, 1'b0, 1'b0);
        drain();

        av = 33; bv = 66;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = W'(av); b = W'(bv); cin = 1'b0; sub = 1'b0;
            step();
            check("stream_accept", 64'(accepted), 64'(1'b1));
            av = av * 10 + 3; bv = bv * 10 + 6;
        end
        drain();

        send(30'h3FFFFFFF, 30'd0, 1'b1, 1'b0);
        send(30'h1FFFFFFF, 30'd1, 1'b0, 1'b0);
        send(30'd5, 30'd7, 1'b0, 1'b1);
        send(30'd7, 30'd5, 1'b1, 1'b1);
        drain();

        a = 30'd3; b = 30'd6; cin = 1'b0; sub = 1'b0; n_a = 10'd3; n_b = 10'd6;
        p_in_valid = 1'b1; n_in_valid = 1'b1;
        step();
        drain();

        lat_chk = 1'b0;
        d0 = delivered;
        fill3();
        check("bp_in_ready_low", 64'(in_ready), 64'(1'b0));
        in_valid = 1'b1; a = W'($urandom()); b = W'($urandom());
        for (int k = 0; k < 4; k++) begin
            step();
            check("bp_hold_valid", 64'(out_valid), 64'(1'b1));
            check("bp_hold_sum", 64'(sum), 64'(q[0].s[W-1:0]));
            check("bp_hold_cout", 64'(cout), 64'(q[0].c));
            check("bp_no_accept", 64'(accepted), 64'(1'b0));
        end
        out_ready = 1'b1;
        #1;
        check("full_in_ready", 64'(in_ready), 64'(1'b1));
        cnt = 3;
        for (int k = 0; k < 20 && cnt < 5; k++) begin
            step();
            if (accepted) begin
                cnt++;
                a = W'($urandom()); b = W'($urandom());
            end
        end
        drain();
        check("bp_delivered", 64'(delivered - d0), 64'(5));

        for (int k = 0; k < 80; k++) begin
            in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 2) != 0);
            a = W'($urandom()); b = W'($urandom());
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            p_in_valid = 1'($urandom_range(0, 1)); n_in_valid = 1'($urandom_range(0, 1));
            n_a = W2'($urandom()); n_b = W2'($urandom());
            step();
        end
        drain();

        fill3();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(1'b0));
        check("midrst_sum", 64'(sum), 64'(0));
        check("midrst_cout", 64'(cout), 64'(1'b0));
        check("midrst_ovf", 64'(ovf), 64'(1'b0));
        check("midrst_in_ready", 64'(in_ready), 64'(1'b1));
        q.delete(); pq.delete(); nq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        lat_chk = 1'b1;
        send(30'd3, 30'd6, 1'b0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
